// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial ALU.
// Contents:
//   NIB_W   - width of one adder pass (4 bits)
//   op_e    - operation encoding presented on the op port
//   state_e - sequencer states
package alu_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_INC = 2'b10,
    OP_CMP = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/ripple_adder4.sv
// Existing 4-bit ripple-carry adder that sits beside the sequencer at the
// ALU top level.
// Ports:
//   a, b  - nibble operands
//   cin   - carry-in
//   s     - sum nibble
//   c4    - carry-out of bit 3
//   v     - signed overflow (carry into bit 3 xor carry out of bit 3)
module ripple_adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       c4,
  output logic       v
);

  logic [4:0] carry_s;

  // Bit-by-bit full-adder chain.
  always_comb begin
    s          = 4'h0;
    carry_s    = 5'b0_0000;
    carry_s[0] = cin;
    for (int i = 0; i < 4; i++) begin
      s[i]         = a[i] ^ b[i] ^ carry_s[i];
      carry_s[i+1] = (a[i] & b[i]) | (a[i] & carry_s[i]) | (b[i] & carry_s[i]);
    end
  end

  assign c4 = carry_s[4];
  assign v  = carry_s[3] ^ carry_s[4];

endmodule

// File: rtl/alu_nibble_seq.sv
// Nibble-serial ALU sequencer. Feeds one 4-bit slice of the operands per
// cycle to an external 4-bit adder and assembles a W = 4*NIB bit result.
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   start_valid/start_ready - request handshake (ready only in IDLE)
//   op, a, b                - operation and operands
//   add_a, add_b, add_cin   - drive to the external adder (zero outside RUN)
//   add_s, add_c4, add_v    - combinational adder results
//   result                  - registered result (unchanged by CMP)
//   flag_z/n/c/v            - registered flags (C = no-borrow for SUB/CMP)
//   done                    - one-cycle completion pulse
module alu_nibble_seq
  import alu_pkg::*;
#(
  parameter int NIB = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [1:0]           op,
  input  logic [NIB_W*NIB-1:0] a,
  input  logic [NIB_W*NIB-1:0] b,
  output logic [NIB_W-1:0]     add_a,
  output logic [NIB_W-1:0]     add_b,
  output logic                 add_cin,
  input  logic [NIB_W-1:0]     add_s,
  input  logic                 add_c4,
  input  logic                 add_v,
  output logic [NIB_W*NIB-1:0] result,
  output logic                 flag_z,
  output logic                 flag_n,
  output logic                 flag_c,
  output logic                 flag_v,
  output logic                 done
);

  localparam int W     = NIB_W * NIB;
  localparam int IDX_W = 2;

  state_e           state_r, state_nxt_s;
  logic [IDX_W-1:0] idx_r;
  logic             carry_r;
  logic [W-1:0]     a_r, b_r;
  op_e              op_r;
  logic             zacc_r;
  logic [W-1:0]     sum_r;     // nibbles built up during RUN
  logic [W-1:0]     sum_nxt_s;
  logic [W-1:0]     result_r;
  logic             flag_z_r, flag_n_r, flag_c_r, flag_v_r, done_r;
  logic [NIB_W-1:0] a_nib_s, b_nib_s;
  logic             last_s;
  logic             nib_zero_s;
  logic [W-1:0]     b_lat_s;

  assign last_s     = (idx_r == IDX_W'(NIB - 1));
  assign nib_zero_s = (add_s == 4'h0);

  // Operand B as stored at accept: inverted for subtraction, zero for increment.
  always_comb begin
    b_lat_s = b;
    case (op_e'(op))
      OP_SUB, OP_CMP: b_lat_s = ~b;
      OP_INC:         b_lat_s = '0;
      default:        b_lat_s = b;
    endcase
  end

  // Select the current nibble of each operand and merge add_s into the accumulator.
  always_comb begin
    a_nib_s   = 4'h0;
    b_nib_s   = 4'h0;
    sum_nxt_s = sum_r;
    for (int i = 0; i < NIB; i++) begin
      a_nib_s = (idx_r == IDX_W'(i)) ? a_r[NIB_W*i +: NIB_W] : a_nib_s;
      b_nib_s = (idx_r == IDX_W'(i)) ? b_r[NIB_W*i +: NIB_W] : b_nib_s;
      sum_nxt_s[NIB_W*i +: NIB_W] = (idx_r == IDX_W'(i)) ? add_s : sum_r[NIB_W*i +: NIB_W];
    end
  end

  // Next-state logic and adder drive; adder inputs are only live in RUN.
  always_comb begin
    state_nxt_s = state_r;
    add_a       = 4'h0;
    add_b       = 4'h0;
    add_cin     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_valid) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        add_a = a_nib_s;
        add_b = b_nib_s;
        // First pass injects +1 for two's-complement subtract and increment.
        add_cin = (idx_r == 2'd0) ? (op_r != OP_ADD) : carry_r;
        if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath: operand latch, per-nibble carry/zero tracking, result and flag update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r    <= 2'd0;
      carry_r  <= 1'b0;
      a_r      <= '0;
      b_r      <= '0;
      op_r     <= OP_ADD;
      zacc_r   <= 1'b0;
      sum_r    <= '0;
      result_r <= '0;
      flag_z_r <= 1'b0;
      flag_n_r <= 1'b0;
      flag_c_r <= 1'b0;
      flag_v_r <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_valid) begin
            a_r     <= a;
            b_r     <= b_lat_s;
            op_r    <= op_e'(op);
            idx_r   <= 2'd0;
            carry_r <= 1'b0;
            zacc_r  <= 1'b1;
            sum_r   <= '0;
          end
        end
        ST_RUN: begin
          carry_r <= add_c4;
          sum_r   <= sum_nxt_s;
          zacc_r  <= zacc_r & nib_zero_s;
          if (last_s) begin
            // Result is published only here so it stays stable between operations.
            if (op_r != OP_CMP) begin
              result_r <= sum_nxt_s;
            end
            flag_c_r <= add_c4;
            flag_v_r <= add_v;
            flag_n_r <= add_s[3];
            flag_z_r <= zacc_r & nib_zero_s;
            done_r   <= 1'b1;
          end else begin
            idx_r <= idx_r + 2'd1;
          end
        end
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end

  assign start_ready = (state_r == ST_IDLE);
  assign result      = result_r;
  assign flag_z      = flag_z_r;
  assign flag_n      = flag_n_r;
  assign flag_c      = flag_c_r;
  assign flag_v      = flag_v_r;
  assign done        = done_r;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Self-checking bench for alu_nibble_seq (NIB=2) wired to the real 4-bit adder.
module tb_alu_nibble_seq;

  localparam int NIB = 2;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic [3:0]   add_a, add_b, add_s;
  logic         add_cin, add_c4, add_v;
  logic [W-1:0] result;
  logic         flag_z, flag_n, flag_c, flag_v, done;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] last_res;

  always #5 clk = ~clk;

  alu_nibble_seq #(.NIB(NIB)) dut (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
    .op(op), .a(a), .b(b), .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_c4(add_c4), .add_v(add_v), .result(result),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v), .done(done)
  );

  ripple_adder4 adder (
    .a(add_a), .b(add_b), .cin(add_cin), .s(add_s), .c4(add_c4), .v(add_v)
  );

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   zncv;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model from plain integer arithmetic on the whole word.
  task automatic model(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic [W-1:0] prev, output logic [W-1:0] res, output logic [3:0] zncv);
    int ua, ub, sa, sb, u, s;
    logic [W-1:0] r;
    logic c, v;
    ua = int'(va);
    ub = int'(vb);
    sa = int'($signed(va));
    sb = int'($signed(vb));
    case (o)
      2'd0: begin u = ua + ub; s = sa + sb; c = (u > 255); end
      2'd2: begin u = ua + 1;  s = sa + 1;  c = (u > 255); end
      default: begin u = ua - ub; s = sa - sb; c = (ua >= ub); end
    endcase
    r = u[W-1:0];
    v = (s > 127) || (s < -128);
    res  = (o == 2'd3) ? prev : r;
    zncv = {(r == 8'h00), r[W-1], c, v};
  endtask

  // Issue one request and check latency, mid-run hold, outputs and flags.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] er, input logic [3:0] ez, input string tag);
    int n;
    int done_at;
    int pulses;
    n = 0;
    while (!start_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready_before"}, {31'd0, start_ready}, 32'd1);
    start_valid = 1'b1;
    op = o;
    a  = va;
    b  = vb;
    @(posedge clk);
    done_at = -1;
    pulses  = 0;
    for (int k = 0; k <= NIB + 1; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start_valid = 1'b0;
        chk({tag, "_hold_mid_run"}, {24'd0, result}, {24'd0, last_res});
        chk({tag, "_ready_in_run"}, {31'd0, start_ready}, 32'd0);
      end
      if (done) begin
        pulses++;
        if (done_at < 0) done_at = k;
      end
      if (k == NIB) begin
        chk({tag, "_result"}, {24'd0, result}, {24'd0, er});
        chk({tag, "_zncv"}, {28'd0, flag_z, flag_n, flag_c, flag_v}, {28'd0, ez});
        chk({tag, "_adder_idle_in_done"}, {23'd0, add_a, add_b, add_cin}, 32'd0);
      end
    end
    chk({tag, "_done_latency"}, done_at, NIB);
    chk({tag, "_done_pulses"}, pulses, 1);
    chk({tag, "_ready_after"}, {31'd0, start_ready}, 32'd1);
    last_res = er;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500us");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] er;
    logic [3:0]   ez;
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;
    int ready_low;
    int cnt;

    tbl[0] = '{2'd0, 8'h7F, 8'h01, 8'h80, 4'b0101};
    tbl[1] = '{2'd1, 8'h00, 8'h01, 8'hFF, 4'b0100};
    tbl[2] = '{2'd0, 8'hFF, 8'h01, 8'h00, 4'b1010};
    tbl[3] = '{2'd2, 8'h0F, 8'h00, 8'h10, 4'b0000};
    tbl[4] = '{2'd1, 8'h80, 8'h01, 8'h7F, 4'b0011};
    tbl[5] = '{2'd0, 8'h7F, 8'h01, 8'h80, 4'b0101};
    tbl[6] = '{2'd3, 8'h55, 8'h55, 8'h80, 4'b1010};
    tbl[7] = '{2'd3, 8'h10, 8'h20, 8'h80, 4'b0100};

    rst_n = 1'b0;
    start_valid = 1'b0;
    op = 2'd0;
    a = 8'h00;
    b = 8'h00;
    last_res = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_result", {24'd0, result}, 32'd0);
    chk("reset_flags_done", {27'd0, flag_z, flag_n, flag_c, flag_v, done}, 32'd0);
    chk("reset_adder_drive", {23'd0, add_a, add_b, add_cin}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", {31'd0, start_ready}, 32'd1);

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].zncv, $sformatf("vec%0d", i));
    end

    // start_valid held high: second request waits for IDLE; operands not re-sampled.
    @(negedge clk);
    start_valid = 1'b1;
    op = 2'd0;
    a  = 8'h12;
    b  = 8'h34;
    @(posedge clk);
    ready_low = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        op = 2'd1;
        a  = 8'h50;
        b  = 8'h20;
      end
      if (!start_ready) ready_low++;
      if (k == 2) begin
        chk("b2b_first_done", {31'd0, done}, 32'd1);
        chk("b2b_first_result", {24'd0, result}, 32'h46);
      end
    end
    chk("b2b_ready_low_cycles", ready_low, 3);
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    chk("b2b_second_accepted", {31'd0, start_ready}, 32'd0);
    cnt = 0;
    while (!done && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    chk("b2b_second_done_seen", {31'd0, done}, 32'd1);
    chk("b2b_second_result", {24'd0, result}, 32'h30);
    chk("b2b_second_znc", {29'd0, flag_z, flag_n, flag_c}, 32'b001);
    last_res = 8'h30;
    @(negedge clk);

    // Reset during the first RUN cycle.
    start_valid = 1'b1;
    op = 2'd0;
    a  = 8'h01;
    b  = 8'h01;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_result", {24'd0, result}, 32'd0);
    chk("rst_mid_flags_done", {27'd0, flag_z, flag_n, flag_c, flag_v, done}, 32'd0);
    @(negedge clk);
    start_valid = 1'b0;
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("rst_no_done", cnt, 0);
    last_res = 8'h00;
    run_op(2'd0, 8'h22, 8'h33, 8'h55, 4'b0000, "post_rst");

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = 8'($urandom);
      rb = 8'($urandom);
      model(ro, ra, rb, last_res, er, ez);
      run_op(ro, ra, rb, er, ez, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
